bit_capture: RTL

- Downstream consumer of the single-bit registered outputs of the timing-example top (e.g. `out`, `out2`).
- Deserializes a qualified 1-bit stream, LSB first, into WIDTH-bit words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface.
- Gives the STA flow a realistic multi-flop, multi-path capture stage on one clock domain.

---
 rtl/bit_capture_pkg.sv | 18 +
 rtl/bit_capture_fifo.sv | 50 +++++
 rtl/bit_capture.sv | 76 +++++++
 3 files changed

// File: rtl/bit_capture_pkg.sv
// bit_capture_pkg: shared defaults, level-width helper and FIFO entry type (BIT_CAPTURE_PARITY_EN adds the parity field)
package bit_capture_pkg;
   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;
   localparam int MAX_WIDTH = 32;

   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // data is sized for the widest legal word; narrower builds leave the upper bits at zero
   typedef struct packed {
      logic [MAX_WIDTH-1:0] data;
`ifdef BIT_CAPTURE_PARITY_EN
      logic                 par;
`endif
   } entry_t;
endpackage

// File: rtl/bit_capture_fifo.sv
// bit_capture_fifo: synchronous DEPTH-entry FIFO with separate level counter; push while full succeeds only alongside a pop
module bit_capture_fifo import bit_capture_pkg::*; #(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  entry_t                   din_i,
   output entry_t                   dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [lvl_w(DEPTH)-1:0]  level_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);
   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]   lvl_q, lvl_d;
   logic            push_ok, pop_ok;

   assign full_o  = lvl_q == LW'(DEPTH);
   assign empty_o = lvl_q == '0;
   assign level_o = lvl_q;
   assign dout_o  = mem_q[rd_q];

   // a pop frees the slot the same-cycle push needs when full
   always_comb begin
      pop_ok  = pop_i && !empty_o;
      push_ok = push_i && (!full_o || pop_ok);
      wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
      rd_d    = pop_ok ? rd_q + PW'(1) : rd_q;
      lvl_d   = lvl_q + LW'(push_ok) - LW'(pop_ok);
   end

   // pointer, level and storage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
         if (push_ok) mem_q[wr_q] <= din_i;
      end
   end
endmodule

// File: rtl/bit_capture.sv
// bit_capture: LSB-first serial-to-word deserializer feeding a valid/ready FIFO; BIT_CAPTURE_PARITY_EN adds word_par
module bit_capture import bit_capture_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bit_in,
   input  logic                     bit_vld,
   output logic [WIDTH-1:0]         word_data,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic [lvl_w(DEPTH)-1:0]  level,
   output logic                     overflow,
`ifdef BIT_CAPTURE_PARITY_EN
   output logic                     word_par,
`endif
   input  logic                     ovf_clr
);
   localparam int CW = $clog2(WIDTH);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-2:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] word;
   logic             ovf_q, ovf_d, done, pop, drop, full, empty, unused_hi;
   entry_t           push_e, head;

   assign word_valid = !empty;
   assign word_data  = head.data[WIDTH-1:0];
   assign overflow   = ovf_q;
   assign unused_hi  = ^head.data;
`ifdef BIT_CAPTURE_PARITY_EN
   assign word_par   = head.par;
`endif

   // the top bit is never stored: the completing bit goes straight into the pushed word
   always_comb begin
      done    = bit_vld && cnt_q == CW'(WIDTH - 1);
      pop     = word_ready && word_valid;
      drop    = done && full && !pop;
      word    = {bit_in, shreg_q};
      shreg_d = shreg_q;
      if (bit_vld && !done) shreg_d[cnt_q] = bit_in;
      cnt_d   = !bit_vld ? cnt_q : done ? '0 : cnt_q + CW'(1);
      ovf_d   = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
      push_e  = '0;
      push_e.data[WIDTH-1:0] = word;
`ifdef BIT_CAPTURE_PARITY_EN
      push_e.par = ^word;
`endif
   end

   // bit counter, partial word and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         ovf_q   <= ovf_d;
      end
   end

   bit_capture_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (done),
      .pop_i   (pop),
      .din_i   (push_e),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );
endmodule
